pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter BOOT_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 SHALL have parameter STAT_W, default 32: statistics counter width.
REQ-003 SHALL have ports as follows, and SHALL use one clock; reset is synchronous and active-low:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, 0 = reset.
- StallF  in  1  hold fetch PC.
- PC_SEL  in  1  predictor says taken.
- PC_PRE  in  32  predicted target.
- prefail  in  1  EX: predicted taken, actually not taken.
- fill  in  1  EX: predicted not taken, actually taken.
- BranchTarget  in  32  EX branch target.
- PCE  in  32  EX instruction PC.
- JalrE  in  1  EX jalr.
- JalrTarget  in  32  EX jalr target.
- JalD  in  1  ID jal.
- JalTarget  in  32  ID jal target.
- BranchE  in  1  EX conditional branch valid, for statistics.
- PCF  out  32  current fetch PC.
- PCF_valid  out  1  PCF is a real fetch.
- redirect  out  1  PCF was loaded from an EX redirect this cycle.
- br_cnt  out  STAT_W  branches resolved.
- miss_cnt  out  STAT_W  mispredicts.

Function
REQ-004 SHALL hold PCF in a register; all next-PC selection SHALL take effect on the next rising clk (1-cycle latency).
REQ-005 SHALL implement FSM BOOT -> RUN: BOOT lasts exactly one cycle after reset release with PCF=BOOT_PC and PCF_valid=0; RUN sets PCF_valid=1; no other transitions except reset to BOOT.
REQ-006 SHALL select next PC in priority: EX redirect > pending redirect > JalD > PC_SEL > PCF+4.
REQ-007 EX redirect priority SHALL be prefail (PCE+4) > fill (BranchTarget) > JalrE (JalrTarget).
REQ-008 SHALL force bits [1:0] of every target (PC_PRE, BranchTarget, JalrTarget, JalTarget) to 0.
REQ-009 SHALL compute PCF+4 and PCE+4 modulo 2^32: 32'hFFFF_FFFC+4 = 0.
REQ-010 When StallF=0, an EX redirect SHALL load PCF next cycle and assert redirect for that cycle.
REQ-011 When StallF=1, an EX redirect SHALL be latched into a pending register, and PCF SHALL hold.
REQ-012 A later EX redirect during the same stall SHALL overwrite the pending address.
REQ-013 The first cycle with StallF=0 SHALL load the pending address, clear pending, and assert redirect.
REQ-014 An EX redirect coincident with StallF=0 and pending valid SHALL win; pending SHALL be cleared.
REQ-015 JalD, PC_SEL and sequential increment SHALL be ignored while StallF=1 or pending is valid.
REQ-016 In BOOT, SHALL ignore all redirect and prediction inputs.

Reset
REQ-017 rst=0 at a rising edge SHALL set PCF=BOOT_PC, PCF_valid=0, redirect=0, pending=0, counters=0, and FSM=BOOT.
REQ-018 Reset mid-stall or with a pending redirect SHALL discard the pending address.

Configuration
REQ-019 Macro PC_GEN_STAT_EN defined: br_cnt SHALL increment on each cycle with BranchE=1 and StallF independent.
REQ-020 Under PC_GEN_STAT_EN, miss_cnt SHALL increment on each cycle with prefail|fill.
REQ-021 Under PC_GEN_STAT_EN, both counters SHALL saturate at all-ones.
REQ-022 Macro PC_GEN_STAT_EN undefined: br_cnt and miss_cnt SHALL be tied to 0 and no counter registers synthesized.

Verification
REQ-023 Reset with BOOT_PC=32'h100, release, no events -> PCF_valid=0 for one cycle with PCF=32'h100, then PCF=32'h100 valid, then 32'h104, 32'h108.
REQ-024 PCF=32'h200, PC_SEL=1, PC_PRE=32'h3A2 -> next PCF=32'h3A0; same cycle with JalD=1, JalTarget=32'h500 -> next PCF=32'h500.
REQ-025 prefail=1 with PCE=32'h3FC, fill=1, BranchTarget=32'h800 -> next PCF=32'h400, redirect=1 for one cycle, miss_cnt increments by 1.
REQ-026 StallF=1 for 3 cycles; fill with BranchTarget=32'h600 in cycle 1, JalrE with JalrTarget=32'h700 in cycle 2 -> PCF holds; after StallF=0, PCF=32'h700, redirect=1 once.
REQ-027 PCF=32'hFFFF_FFFC, no events -> next PCF=32'h0.
REQ-028 Pending redirect set, then rst=0 -> PCF=BOOT_PC, redirect never asserted afterwards without a new EX redirect.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with EX redirect, stall-time pending redirect, JAL and predictor paths.
// Define PC_GEN_STAT_EN to build the saturating branch/mispredict statistics counters.
module pc_gen #(
    parameter logic [31:0] BOOT_PC = 32'h0000_0000,
    parameter int          STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallF,
    input  logic              PC_SEL,
    input  logic [31:0]       PC_PRE,
    input  logic              prefail,
    input  logic              fill,
    input  logic [31:0]       BranchTarget,
    input  logic [31:0]       PCE,
    input  logic              JalrE,
    input  logic [31:0]       JalrTarget,
    input  logic              JalD,
    input  logic [31:0]       JalTarget,
    input  logic              BranchE,
    output logic [31:0]       PCF,
    output logic              PCF_valid,
    output logic              redirect,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [0:0]  state;
    logic        pend_valid;
    logic [31:0] pend_addr;
    logic        ex_valid;
    logic [31:0] ex_addr;

    // The oldest mispredict (prefail) wins; its fall-through address is PCE+4, not a target.
    always_comb begin
        ex_valid = prefail | fill | JalrE;
        ex_addr  = JalrTarget & ALIGN_MASK;
        if (prefail) begin
            ex_addr = PCE + 32'd4;
        end else if (fill) begin
            ex_addr = BranchTarget & ALIGN_MASK;
        end
    end

    assign PCF_valid = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= BOOT;
            PCF        <= BOOT_PC;
            redirect   <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else if (state == BOOT) begin
            state    <= RUN;
            redirect <= 1'b0;
        end else begin
            redirect <= 1'b0;
            if (StallF) begin
                // Remember only the youngest EX redirect seen while fetch is frozen.
                if (ex_valid) begin
                    pend_valid <= 1'b1;
                    pend_addr  <= ex_addr;
                end
            end else if (ex_valid) begin
                PCF        <= ex_addr;
                redirect   <= 1'b1;
                pend_valid <= 1'b0;
            end else if (pend_valid) begin
                PCF        <= pend_addr;
                redirect   <= 1'b1;
                pend_valid <= 1'b0;
            end else if (JalD) begin
                PCF <= JalTarget & ALIGN_MASK;
            end else if (PC_SEL) begin
                PCF <= PC_PRE & ALIGN_MASK;
            end else begin
                PCF <= PCF + 32'd4;
            end
        end
    end

`ifdef PC_GEN_STAT_EN
    logic [STAT_W-1:0] br_q;
    logic [STAT_W-1:0] miss_q;
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    // Counters stick at all-ones rather than wrapping so overflow is visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            br_q   <= '0;
            miss_q <= '0;
        end else begin
            if (BranchE && (br_q != '1)) begin
                br_q <= br_q + STAT_ONE;
            end
            if ((prefail || fill) && (miss_q != '1)) begin
                miss_q <= miss_q + STAT_ONE;
            end
        end
    end

    assign br_cnt   = br_q;
    assign miss_cnt = miss_q;
`else
    logic unused_branch;
    assign unused_branch = BranchE;
    assign br_cnt   = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen; a driver pushes reference-model expectations, a monitor pops and compares.
// Honours PC_GEN_STAT_EN the same way the design does.
module tb_pc_gen;

    localparam logic [31:0] BOOT_PC = 32'h0000_0100;
    localparam int          STAT_W  = 32;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        pc_sel;
        logic [31:0] pc_pre;
        logic        prefail;
        logic        fill;
        logic [31:0] br_target;
        logic [31:0] pce;
        logic        jalr;
        logic [31:0] jalr_target;
        logic        jal;
        logic [31:0] jal_target;
        logic        branch;
    } stim_t;

    typedef struct {
        logic [31:0]       pcf;
        logic              valid;
        logic              redirect;
        logic [STAT_W-1:0] br;
        logic [STAT_W-1:0] miss;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              StallF;
    logic              PC_SEL;
    logic [31:0]       PC_PRE;
    logic              prefail;
    logic              fill;
    logic [31:0]       BranchTarget;
    logic [31:0]       PCE;
    logic              JalrE;
    logic [31:0]       JalrTarget;
    logic              JalD;
    logic [31:0]       JalTarget;
    logic              BranchE;
    logic [31:0]       PCF;
    logic              PCF_valid;
    logic              redirect;
    logic [STAT_W-1:0] br_cnt;
    logic [STAT_W-1:0] miss_cnt;

    pc_gen #(.BOOT_PC(BOOT_PC), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PC_SEL(PC_SEL), .PC_PRE(PC_PRE),
        .prefail(prefail), .fill(fill), .BranchTarget(BranchTarget), .PCE(PCE),
        .JalrE(JalrE), .JalrTarget(JalrTarget), .JalD(JalD), .JalTarget(JalTarget),
        .BranchE(BranchE), .PCF(PCF), .PCF_valid(PCF_valid), .redirect(redirect),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference model state: fetch address, whether boot finished, a redirect mailbox and counters.
    logic [31:0]       m_pc = BOOT_PC;
    logic              m_running = 1'b0;
    logic              m_redirect = 1'b0;
    logic [31:0]       m_pending[$];
    logic [STAT_W-1:0] m_br = '0;
    logic [STAT_W-1:0] m_miss = '0;

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic modelStep(input stim_t s);
        logic [31:0] target;
        logic        have_ex;
        if (!s.rst) begin
            m_pc = BOOT_PC;
            m_running = 1'b0;
            m_redirect = 1'b0;
            m_pending.delete();
            m_br = '0;
            m_miss = '0;
            return;
        end
`ifdef PC_GEN_STAT_EN
        if (s.branch && m_br != {STAT_W{1'b1}}) m_br = m_br + 1;
        if ((s.prefail || s.fill) && m_miss != {STAT_W{1'b1}}) m_miss = m_miss + 1;
`endif
        m_redirect = 1'b0;
        if (!m_running) begin
            m_running = 1'b1;
            return;
        end
        have_ex = s.prefail || s.fill || s.jalr;
        if (s.prefail)   target = s.pce + 32'd4;
        else if (s.fill) target = aligned(s.br_target);
        else             target = aligned(s.jalr_target);
        if (s.stall) begin
            if (have_ex) begin
                m_pending.delete();
                m_pending.push_back(target);
            end
        end else if (have_ex) begin
            m_pc = target;
            m_redirect = 1'b1;
            m_pending.delete();
        end else if (m_pending.size() != 0) begin
            m_pc = m_pending.pop_front();
            m_redirect = 1'b1;
        end else if (s.jal) begin
            m_pc = aligned(s.jal_target);
        end else if (s.pc_sel) begin
            m_pc = aligned(s.pc_pre);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b1; s.stall = 1'b0; s.pc_sel = 1'b0; s.pc_pre = '0;
        s.prefail = 1'b0; s.fill = 1'b0; s.br_target = '0; s.pce = '0;
        s.jalr = 1'b0; s.jalr_target = '0; s.jal = 1'b0; s.jal_target = '0;
        s.branch = 1'b0;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst; StallF = s.stall; PC_SEL = s.pc_sel; PC_PRE = s.pc_pre;
        prefail = s.prefail; fill = s.fill; BranchTarget = s.br_target; PCE = s.pce;
        JalrE = s.jalr; JalrTarget = s.jalr_target; JalD = s.jal; JalTarget = s.jal_target;
        BranchE = s.branch;
        modelStep(s);
        e.pcf = m_pc; e.valid = m_running; e.redirect = m_redirect;
        e.br = m_br; e.miss = m_miss;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        n_checks += 5;
        if (PCF !== e.pcf) begin
            n_fails++;
            $display("[TB] FAIL pcf @%0t: got %h expected %h", $time, PCF, e.pcf);
        end
        if (PCF_valid !== e.valid) begin
            n_fails++;
            $display("[TB] FAIL pcf_valid @%0t: got %b expected %b", $time, PCF_valid, e.valid);
        end
        if (redirect !== e.redirect) begin
            n_fails++;
            $display("[TB] FAIL redirect @%0t: got %b expected %b", $time, redirect, e.redirect);
        end
        if (br_cnt !== e.br) begin
            n_fails++;
            $display("[TB] FAIL br_cnt @%0t: got %0d expected %0d", $time, br_cnt, e.br);
        end
        if (miss_cnt !== e.miss) begin
            n_fails++;
            $display("[TB] FAIL miss_cnt @%0t: got %0d expected %0d", $time, miss_cnt, e.miss);
        end
    endtask

    // Monitor: the DUT presents a new PCF every cycle, so compare one expectation per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0; StallF = 1'b0; PC_SEL = 1'b0; PC_PRE = '0; prefail = 1'b0; fill = 1'b0;
        BranchTarget = '0; PCE = '0; JalrE = 1'b0; JalrTarget = '0; JalD = 1'b0;
        JalTarget = '0; BranchE = 1'b0;

        // Boot: reset, release, then plain sequential fetch.
        s = idle(); s.rst = 1'b0;
        repeat (2) applyStimulus(s);
        repeat (4) applyStimulus(idle());

        // Predictor target is aligned; a JAL in ID outranks it.
        s = idle(); s.jal = 1'b1; s.jal_target = 32'h200;
        applyStimulus(s);
        s = idle(); s.pc_sel = 1'b1; s.pc_pre = 32'h3A2;
        applyStimulus(s);
        s = idle(); s.pc_sel = 1'b1; s.pc_pre = 32'h3A2; s.jal = 1'b1; s.jal_target = 32'h500;
        applyStimulus(s);

        // prefail beats fill; PCE+4 used.
        s = idle(); s.prefail = 1'b1; s.pce = 32'h3FC; s.fill = 1'b1; s.br_target = 32'h800;
        s.branch = 1'b1;
        applyStimulus(s);
        repeat (2) applyStimulus(idle());

        // Two redirects during a 3-cycle stall; the later one is taken on release.
        s = idle(); s.stall = 1'b1; s.fill = 1'b1; s.br_target = 32'h600; s.branch = 1'b1;
        applyStimulus(s);
        s = idle(); s.stall = 1'b1; s.jalr = 1'b1; s.jalr_target = 32'h701;
        applyStimulus(s);
        s = idle(); s.stall = 1'b1;
        applyStimulus(s);
        repeat (3) applyStimulus(idle());

        // Pending redirect overridden by a fresh EX redirect on release.
        s = idle(); s.stall = 1'b1; s.fill = 1'b1; s.br_target = 32'h900;
        applyStimulus(s);
        s = idle(); s.jalr = 1'b1; s.jalr_target = 32'hA00;
        applyStimulus(s);
        repeat (2) applyStimulus(idle());

        // Wrap of the sequential increment.
        s = idle(); s.jal = 1'b1; s.jal_target = 32'hFFFF_FFFF;
        applyStimulus(s);
        repeat (2) applyStimulus(idle());

        // Reset while a redirect is pending discards it.
        s = idle(); s.stall = 1'b1; s.fill = 1'b1; s.br_target = 32'hC00;
        applyStimulus(s);
        s = idle(); s.rst = 1'b0; s.stall = 1'b1;
        applyStimulus(s);
        repeat (5) applyStimulus(idle());

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst         = ($urandom_range(0, 49) != 0);
            s.stall       = ($urandom_range(0, 9) < 3);
            s.pc_sel      = ($urandom_range(0, 4) == 0);
            s.pc_pre      = $urandom;
            s.prefail     = ($urandom_range(0, 9) == 0);
            s.fill        = ($urandom_range(0, 9) == 0);
            s.br_target   = $urandom;
            s.pce         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            s.jalr        = ($urandom_range(0, 9) == 0);
            s.jalr_target = $urandom;
            s.jal         = ($urandom_range(0, 9) == 0);
            s.jal_target  = $urandom;
            s.branch      = ($urandom_range(0, 2) == 0);
            applyStimulus(s);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL drain: got %0d queued expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
